sram_bank_mw: RTL
=================

# sram_bank_mw

Parametrised single-port synchronous SRAM model. It generalises the fixed 16-entry, 64-bit scratch memory with configurable width and depth, per-lane write masking, optional output pipelining, a read-valid strobe, out-of-range detection and a self-clearing initialisation sequencer. It is the storage primitive for activation, weight and partial-sum buffers in the core, and it keeps the CEN/WEN active-low request convention.

## Interface
Parameters:
- DATA_W, 64, word width in bits; must be a multiple of LANE_W.
- DEPTH, 16, number of words; any value 1..2^ADDR_W.
- ADDR_W, 4, address width.
- LANE_W, 8, write-mask granularity in bits; NLANE = DATA_W/LANE_W.
- OUT_REG, 0, 0 gives read latency 1; 1 adds an output register for read latency 2.

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RESETN  input  1  reset; synchronous and active-low.
- CEN  input  1  chip enable, active-low.
- WEN  input  1  write enable, active-low; 1 means read when CEN=0.
- A  input  ADDR_W  word address.
- D  input  DATA_W  write data.
- BWEN  input  NLANE  per-lane write mask, active-low; bit i covers D[i*LANE_W +: LANE_W].
- Q  output  DATA_W  read data; holds its value between reads.
- QVALID  output  1  one-cycle strobe; Q carries new read data.
- READY  output  1  high when requests are accepted; low during clear.
- ERR  output  1  one-cycle strobe for an out-of-range access (A >= DEPTH).

## Operation
- The state machine has two states, CLEAR and RUN.
- Reset (RESETN=0 at an edge):
  - state becomes CLEAR and the clear counter becomes 0;
  - Q=0, QVALID=0, READY=0, ERR=0, and the OUT_REG pipeline stage is cleared.
- CLEAR:
  - each cycle writes all-zero to mem[counter], then increments the counter;
  - at counter = DEPTH-1 the state moves to RUN on the same edge that writes the last word;
  - CEN/WEN/A/D/BWEN are ignored and no QVALID or ERR is produced.
- RUN: READY=1.
  - CEN=1: idle; Q holds its value.
  - CEN=0, WEN=1, A<DEPTH: read mem[A].
  - CEN=0, WEN=1, A>=DEPTH: read returns all-zero with QVALID=1 and ERR=1 on the same cycle; memory is untouched.
  - CEN=0, WEN=0, A<DEPTH: for each lane i with BWEN[i]=0, mem[A] lane i takes D lane i; lanes with BWEN[i]=1 are preserved. BWEN all-ones is a legal no-op write.
  - CEN=0, WEN=0, A>=DEPTH: write is dropped; ERR pulses the next cycle; Q and QVALID are unaffected.
  - Writes never change Q and never raise QVALID.
- Reset asserted mid-CLEAR or mid-RUN:
  - returns to CLEAR with the counter at 0;
  - a read in flight in the OUT_REG stage is discarded (no QVALID);
  - memory is re-zeroed in full.
- When DEPTH = 2^ADDR_W, out-of-range is unreachable and ERR stays 0.

## Timing
- Clear duration: with RESETN high from edge 0, mem[0] is zeroed at edge 0 (first edge with RESETN=1) and READY is high after edge DEPTH-1, so it is sampled high at edge DEPTH. The first accepted request is at edge DEPTH.
- Read latency: a read sampled at edge t drives Q/QVALID after edge t+1+OUT_REG. QVALID is high for exactly one cycle per read.
- Back-to-back reads, one per cycle, give a continuous QVALID stream in order.
- Write-then-read to the same address on consecutive edges returns the newly written data, merged per BWEN.
- Read-after-write in the same cycle is impossible on a single port.
- ERR timing:
  - read: aligned with the corresponding QVALID;
  - write: one cycle after the request.
- Requests presented while READY=0 are lost. Upstream must gate on READY.

## Test plan
- Reset and clear, DEPTH=16: hold RESETN=0 for 3 cycles, then release. READY stays 0 for 16 edges, then rises. Reading all 16 addresses returns 0. Before the first read, Q=0 and QVALID=0.
- Full write/read, OUT_REG=0: write mem[k]=64'h0101_0101_0101_0101*k for k=0..15, then read k=0..15 back-to-back. QVALID is high for 16 consecutive cycles, each one cycle after its read, with matching data.
- Byte mask: write 64'hFFFF_FFFF_FFFF_FFFF to A=3, then write 64'h1122_3344_5566_7788 with BWEN=8'b1111_0000. Reading A=3 returns 64'hFFFF_FFFF_5566_7788.
- Out-of-range, DEPTH=12: read A=13 gives Q=0, QVALID=1 and ERR=1 together. Write A=14 pulses ERR one cycle later, and a subsequent read of A=0..11 shows every location unchanged.
- OUT_REG=1 latency and reset-mid-op: read A=5 (holding 64'hA5) and confirm Q=64'hA5 two edges later. Then issue a read and assert RESETN=0 on the next edge. No QVALID appears, READY drops, and after the re-clear A=5 reads 0.

Source files
------------

// File: rtl/sram_bank_mw.sv
// -----------------------------------------------------------------------------
// sram_bank_mw
//
// Parametrised single-port synchronous SRAM bank. It serves as the storage
// primitive for the activation, weight and partial-sum buffers. Requests use
// active-low CEN/WEN. Writes are masked per lane through BWEN. Reads return
// data one cycle after the request is sampled, or two cycles when OUT_REG=1.
// A built-in sequencer zeroes the whole array after every reset. READY is low
// while this sequencer runs.
//
// Ports
//   CLK     in   clock, rising edge
//   RESETN  in   synchronous reset, active-low
//   CEN     in   chip enable, active-low
//   WEN     in   write enable, active-low (1 = read when CEN=0)
//   A       in   word address [ADDR_W]
//   D       in   write data [DATA_W]
//   BWEN    in   per-lane write mask, active-low [DATA_W/LANE_W]
//   Q       out  read data; holds its value between reads
//   QVALID  out  one-cycle strobe; Q carries new read data
//   READY   out  requests are accepted (low while clearing)
//   ERR     out  one-cycle strobe for an access with A >= DEPTH
// -----------------------------------------------------------------------------
module sram_bank_mw #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int LANE_W  = 8,
  parameter int OUT_REG = 0
) (
  input  logic                       CLK,
  input  logic                       RESETN,
  input  logic                       CEN,
  input  logic                       WEN,
  input  logic [ADDR_W-1:0]          A,
  input  logic [DATA_W-1:0]          D,
  input  logic [DATA_W/LANE_W-1:0]   BWEN,
  output logic [DATA_W-1:0]          Q,
  output logic                       QVALID,
  output logic                       READY,
  output logic                       ERR
);

  localparam int NLANE = DATA_W / LANE_W;

  // Depth widened by one bit so that DEPTH = 2^ADDR_W is representable.
  // In that case the range test below is always true and ERR stays 0.
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;

  // Decoded request and memory-port controls
  logic              in_range;
  logic              ready;
  logic [NLANE-1:0]  mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_en;     // in-range read: the array is accessed
  logic              rd_req;    // any accepted read, in range or not
  logic              rd_oor;    // accepted read with A >= DEPTH
  logic              wr_oor;    // dropped write with A >= DEPTH

  wire  [DATA_W-1:0] ram_q;

  // First read stage (aligned with the registered array output)
  logic              s1_vld_reg;
  logic              s1_oor_reg;
  logic              werr_reg;
  logic [DATA_W-1:0] s1_data;

  // Data presented to the output register
  logic              out_vld;
  logic              out_oor;
  logic [DATA_W-1:0] out_data;

  // Output registers
  logic [DATA_W-1:0] q_reg;
  logic              qvalid_reg;
  logic              err_reg;

  assign in_range = ({1'b0, A} < DEPTH_X);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // The edge that writes the last word also moves the FSM to RUN.
  // READY is therefore high in the cycle after that edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      CLEAR: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_ADDR) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        state_next = RUN;
      end
      default: begin
        state_next = CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / memory-port decode
  // Requests are qualified with RESETN so that an edge with reset asserted
  // never touches the array.
  // ---------------------------------------------------------------------------
  always_comb begin
    ready     = 1'b0;
    mem_we    = '0;
    mem_addr  = A;
    mem_wdata = D;
    rd_en     = 1'b0;
    rd_req    = 1'b0;
    rd_oor    = 1'b0;
    wr_oor    = 1'b0;
    case (state_reg)
      CLEAR: begin
        mem_addr  = cnt_reg;
        mem_wdata = '0;
        mem_we    = {NLANE{RESETN}};
      end
      RUN: begin
        ready = 1'b1;
        if (RESETN && !CEN) begin
          if (WEN) begin
            rd_req = 1'b1;
            rd_en  = in_range;
            rd_oor = !in_range;
          end else begin
            mem_we = in_range ? ~BWEN : '0;
            wr_oor = !in_range;
          end
        end
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage: one narrow array per lane.
  // Each lane has a single write port and a registered read, so it maps
  // cleanly onto block RAM. Lane masking becomes independent write enables.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
      logic [LANE_W-1:0] mem_lane [0:DEPTH-1];
      logic [LANE_W-1:0] rd_lane_reg;

      always_ff @(posedge CLK) begin
        if (mem_we[gi]) begin
          mem_lane[mem_addr] <= mem_wdata[gi*LANE_W +: LANE_W];
        end
        if (rd_en) begin
          rd_lane_reg <= mem_lane[mem_addr];
        end
      end

      assign ram_q[gi*LANE_W +: LANE_W] = rd_lane_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Read stage 1: tracks whether the registered array output is a real read.
  // An out-of-range read does not access the array. Its data is forced to
  // zero here instead.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      s1_vld_reg <= 1'b0;
      s1_oor_reg <= 1'b0;
      werr_reg   <= 1'b0;
    end else begin
      s1_vld_reg <= rd_req;
      s1_oor_reg <= rd_oor;
      werr_reg   <= wr_oor;
    end
  end

  assign s1_data = s1_oor_reg ? '0 : ram_q;

  // ---------------------------------------------------------------------------
  // Optional extra pipeline stage
  // ---------------------------------------------------------------------------
  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              p_vld_reg;
      logic              p_oor_reg;
      logic [DATA_W-1:0] p_data_reg;

      always_ff @(posedge CLK) begin
        if (!RESETN) begin
          p_vld_reg  <= 1'b0;
          p_oor_reg  <= 1'b0;
          p_data_reg <= '0;
        end else begin
          p_vld_reg  <= s1_vld_reg;
          p_oor_reg  <= s1_oor_reg;
          p_data_reg <= s1_data;
        end
      end

      assign out_vld  = p_vld_reg;
      assign out_oor  = p_oor_reg;
      assign out_data = p_data_reg;
    end else begin : g_noreg
      assign out_vld  = s1_vld_reg;
      assign out_oor  = s1_oor_reg;
      assign out_data = s1_data;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output register
  // Q only updates on a read, so writes and idle cycles leave it unchanged.
  // A write error comes from stage 1 and is not delayed by OUT_REG. It can
  // therefore share a cycle with a read error from an earlier request, so
  // the two sources are ORed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      q_reg      <= '0;
      qvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      qvalid_reg <= out_vld;
      err_reg    <= (out_vld && out_oor) || werr_reg;
      if (out_vld) begin
        q_reg <= out_data;
      end
    end
  end

  assign Q      = q_reg;
  assign QVALID = qvalid_reg;
  assign READY  = ready;
  assign ERR    = err_reg;

endmodule
